redirect_ctrl: RTL and testbench

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

---
 rtl/redirect_ctrl.sv | 153 +++++++++++++++
 tb/tb_redirect_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_ctrl
//   Operand-redirect (forwarding) and load-use stall control for a 5-stage
//   MIPS-style pipeline. It tracks the destination, write-enable and load flags
//   of the instructions in the EX and MEM slots. For the instruction entering
//   EX, it registers which operands must be taken from the result register
//   (R, the instruction now in EX) or from write-back (WB, the one now in MEM).
//
// Ports
//   in_CLK          sole clock, rising edge
//   in_RST          asynchronous active-low reset
//   in_id_rs/rt     source register numbers of the ID instruction
//   in_id_use_rs/rt ID instruction reads rs / rt
//   in_id_syscall   ID instruction is a syscall (reads $2 and $4)
//   in_id_dst       destination register of the ID instruction
//   in_id_regwrite  ID instruction writes in_id_dst
//   in_id_memread   ID instruction is a load
//   in_flush        taken branch: squash the ID instruction
//   in_lock         syscall lock: freeze all state
//   out_ALUREDI     bit0 X<-R, bit1 Y<-R, bit2 X<-WB, bit3 Y<-WB
//   out_SYSREDI     bit0 v0<-R, bit1 a0<-R, bit2 v0<-WB, bit3 a0<-WB
//   out_stall       combinational load-use hazard (hold IF/ID)
//   out_stall_cnt   saturating count of stall cycles
// -----------------------------------------------------------------------------
module redirect_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             in_CLK,
   input  logic             in_RST,
   input  logic [4:0]       in_id_rs,
   input  logic [4:0]       in_id_rt,
   input  logic             in_id_use_rs,
   input  logic             in_id_use_rt,
   input  logic             in_id_syscall,
   input  logic [4:0]       in_id_dst,
   input  logic             in_id_regwrite,
   input  logic             in_id_memread,
   input  logic             in_flush,
   input  logic             in_lock,
   output logic [3:0]       out_ALUREDI,
   output logic [3:0]       out_SYSREDI,
   output logic             out_stall,
   output logic [CNT_W-1:0] out_stall_cnt
);

   localparam logic [4:0] REG_V0 = 5'd2;
   localparam logic [4:0] REG_A0 = 5'd4;

   // A slot supplies register r only if it writes r and r is not $0.
   function automatic logic slot_hit(input logic wr, input logic [4:0] dst,
                                     input logic [4:0] r);
      return wr && (dst == r) && (r != 5'd0);
   endfunction

   // Returns {wb_hit, r_hit}; the newer EX-slot match suppresses the WB match.
   function automatic logic [1:0] redirect(input logic use_r, input logic [4:0] r,
                                           input logic ex_wr, input logic [4:0] ex_dst,
                                           input logic mem_wr, input logic [4:0] mem_dst);
      logic r_hit;
      logic wb_hit;
      r_hit  = use_r && slot_hit(ex_wr, ex_dst, r);
      wb_hit = use_r && !r_hit && slot_hit(mem_wr, mem_dst, r);
      return {wb_hit, r_hit};
   endfunction

   logic [4:0]       ex_dst_q,  ex_dst_d;
   logic             ex_wr_q,   ex_wr_d;
   logic             ex_ld_q,   ex_ld_d;
   logic [4:0]       mem_dst_q, mem_dst_d;
   logic             mem_wr_q,  mem_wr_d;
   logic [3:0]       alu_q,     alu_d;
   logic [3:0]       sys_q,     sys_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic             hazard;
   logic             bubble;
   logic [1:0]       fw_rs, fw_rt, fw_v0, fw_a0;

   // Load-use hazard: the load in EX produces a register the ID instruction reads.
   always_comb begin
      hazard = (in_id_use_rs && slot_hit(ex_wr_q, ex_dst_q, in_id_rs)) ||
               (in_id_use_rt && slot_hit(ex_wr_q, ex_dst_q, in_id_rt)) ||
               (in_id_syscall && (slot_hit(ex_wr_q, ex_dst_q, REG_V0) ||
                                  slot_hit(ex_wr_q, ex_dst_q, REG_A0)));
      out_stall = ex_ld_q && hazard && !in_flush;
      bubble    = in_flush || out_stall;
   end

   always_comb begin
      fw_rs = redirect(in_id_use_rs,  in_id_rs, ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
      fw_rt = redirect(in_id_use_rt,  in_id_rt, ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
      fw_v0 = redirect(in_id_syscall, REG_V0,   ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
      fw_a0 = redirect(in_id_syscall, REG_A0,   ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
   end

   always_comb begin
      ex_dst_d  = ex_dst_q;
      ex_wr_d   = ex_wr_q;
      ex_ld_d   = ex_ld_q;
      mem_dst_d = mem_dst_q;
      mem_wr_d  = mem_wr_q;
      alu_d     = alu_q;
      sys_d     = sys_q;
      cnt_d     = cnt_q;
      if (!in_lock) begin
         mem_dst_d = ex_dst_q;
         mem_wr_d  = ex_wr_q;
         if (bubble) begin
            ex_dst_d = '0;
            ex_wr_d  = 1'b0;
            ex_ld_d  = 1'b0;
            alu_d    = '0;
            sys_d    = '0;
         end else begin
            ex_dst_d = in_id_dst;
            ex_wr_d  = in_id_regwrite;
            ex_ld_d  = in_id_memread;
            alu_d    = {fw_rt[1], fw_rs[1], fw_rt[0], fw_rs[0]};
            sys_d    = {fw_a0[1], fw_v0[1], fw_a0[0], fw_v0[0]};
         end
         if (out_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         ex_dst_q  <= '0;
         ex_wr_q   <= 1'b0;
         ex_ld_q   <= 1'b0;
         mem_dst_q <= '0;
         mem_wr_q  <= 1'b0;
         alu_q     <= '0;
         sys_q     <= '0;
         cnt_q     <= '0;
      end else begin
         ex_dst_q  <= ex_dst_d;
         ex_wr_q   <= ex_wr_d;
         ex_ld_q   <= ex_ld_d;
         mem_dst_q <= mem_dst_d;
         mem_wr_q  <= mem_wr_d;
         alu_q     <= alu_d;
         sys_q     <= sys_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_ALUREDI   = alu_q;
   assign out_SYSREDI   = sys_q;
   assign out_stall_cnt = cnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
module tb_redirect_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic        id_use_rs, id_use_rt, id_syscall, id_regwrite, id_memread;
   logic        flush, lock;
   logic [3:0]  alu, sys;
   logic        stall;
   logic [15:0] cnt;
   logic [3:0]  s_alu, s_sys;
   logic        s_stall;
   logic [3:0]  s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [3:0]  alu;
      logic [3:0]  sys;
      logic [15:0] cnt;
   } exp_t;
   exp_t sbq[$];

   redirect_ctrl u_dut (
      .in_CLK(clk), .in_RST(rst_n),
      .in_id_rs(id_rs), .in_id_rt(id_rt),
      .in_id_use_rs(id_use_rs), .in_id_use_rt(id_use_rt),
      .in_id_syscall(id_syscall), .in_id_dst(id_dst),
      .in_id_regwrite(id_regwrite), .in_id_memread(id_memread),
      .in_flush(flush), .in_lock(lock),
      .out_ALUREDI(alu), .out_SYSREDI(sys),
      .out_stall(stall), .out_stall_cnt(cnt)
   );

   // Narrow counter copy so saturation is reachable in a few dozen cycles.
   redirect_ctrl #(.CNT_W(4)) u_sat (
      .in_CLK(clk), .in_RST(rst_n),
      .in_id_rs(id_rs), .in_id_rt(id_rt),
      .in_id_use_rs(id_use_rs), .in_id_use_rt(id_use_rt),
      .in_id_syscall(id_syscall), .in_id_dst(id_dst),
      .in_id_regwrite(id_regwrite), .in_id_memread(id_memread),
      .in_flush(flush), .in_lock(lock),
      .out_ALUREDI(s_alu), .out_SYSREDI(s_sys),
      .out_stall(s_stall), .out_stall_cnt(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic sc, input logic [4:0] dst,
                         input logic wr, input logic ld);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_syscall = sc; id_dst = dst; id_regwrite = wr; id_memread = ld;
   endtask

   // Push the expectation for the coming edge, then pop and compare after it.
   task automatic tick_exp(input string tag, input logic [3:0] ea, input logic [3:0] es,
                           input logic [15:0] ec);
      exp_t e;
      e.tag = tag; e.alu = ea; e.sys = es; e.cnt = ec;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         check_eq({e.tag, ".alu"}, {28'd0, alu}, {28'd0, e.alu});
         check_eq({e.tag, ".sys"}, {28'd0, sys}, {28'd0, e.sys});
         check_eq({e.tag, ".cnt"}, {16'd0, cnt}, {16'd0, e.cnt});
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; lock = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check_eq("reset.alu",   {28'd0, alu}, 32'd0);
      check_eq("reset.sys",   {28'd0, sys}, 32'd0);
      check_eq("reset.cnt",   {16'd0, cnt}, 32'd0);
      check_eq("reset.stall", {31'd0, stall}, 32'd0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single add forwarded from R.
      set_id(0, 0, 0, 0, 0, 3, 1, 0);  tick_exp("add3",      4'h0, 4'h0, 16'd0);
      set_id(3, 0, 1, 0, 0, 0, 0, 0);  tick_exp("use_rs3",   4'h1, 4'h0, 16'd0);

      // Both slots write 7: EX wins for rs and rt.
      set_id(0, 0, 0, 0, 0, 7, 1, 0);  tick_exp("w7a",       4'h0, 4'h0, 16'd0);
      set_id(0, 0, 0, 0, 0, 7, 1, 0);  tick_exp("w7b",       4'h0, 4'h0, 16'd0);
      set_id(7, 7, 1, 1, 0, 0, 0, 0);  tick_exp("rsrt7",     4'h3, 4'h0, 16'd0);

      // Only MEM slot writes 5.
      set_id(0, 0, 0, 0, 0, 5, 1, 0);  tick_exp("w5",        4'h0, 4'h0, 16'd0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);  tick_exp("nop",       4'h0, 4'h0, 16'd0);
      set_id(0, 5, 0, 1, 0, 0, 0, 0);  tick_exp("rt5_wb",    4'h8, 4'h0, 16'd0);

      // Load-use stall on lw $8.
      set_id(0, 0, 0, 0, 0, 8, 1, 1);  tick_exp("lw8",       4'h0, 4'h0, 16'd0);
      set_id(8, 0, 1, 0, 0, 0, 0, 0);
      #1 check_eq("lw8.stall", {31'd0, stall}, 32'd1);
      tick_exp("lw8.bubble", 4'h0, 4'h0, 16'd1);
      check_eq("lw8.stall_clear", {31'd0, stall}, 32'd0);
      tick_exp("lw8.wb",     4'h4, 4'h0, 16'd1);

      // Syscall: EX writes $2, MEM writes $4.
      set_id(0, 0, 0, 0, 0, 4, 1, 0);  tick_exp("w4",        4'h0, 4'h0, 16'd1);
      set_id(0, 0, 0, 0, 0, 2, 1, 0);  tick_exp("w2",        4'h0, 4'h0, 16'd1);
      set_id(0, 0, 0, 0, 1, 0, 0, 0);  tick_exp("sys_fw",    4'h0, 4'h9, 16'd1);
      set_id(0, 0, 0, 0, 0, 0, 1, 0);  tick_exp("w0a",       4'h0, 4'h0, 16'd1);
      set_id(0, 0, 0, 0, 0, 0, 1, 0);  tick_exp("w0b",       4'h0, 4'h0, 16'd1);
      set_id(0, 0, 0, 0, 1, 0, 0, 0);  tick_exp("sys_r0",    4'h0, 4'h0, 16'd1);

      // Hazard squashed by flush.
      set_id(0, 0, 0, 0, 0, 9, 1, 1);  tick_exp("lw9",       4'h0, 4'h0, 16'd1);
      set_id(0, 9, 0, 1, 0, 0, 0, 0);
      flush = 1'b1;
      #1 check_eq("flush.stall", {31'd0, stall}, 32'd0);
      tick_exp("flush.bubble", 4'h0, 4'h0, 16'd1);
      flush = 1'b0;
      tick_exp("flush.after",  4'h8, 4'h0, 16'd1);

      // Lock for 3 edges while a stall is pending.
      set_id(0, 0, 0, 0, 0, 6, 1, 0);  tick_exp("w6",        4'h0, 4'h0, 16'd1);
      set_id(6, 0, 1, 0, 0, 10, 1, 1); tick_exp("rs6_lw10",  4'h1, 4'h0, 16'd1);
      set_id(0, 10, 0, 1, 0, 0, 0, 0);
      lock = 1'b1;
      #1 check_eq("lock.stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < 3; i++) tick_exp("lock.hold", 4'h1, 4'h0, 16'd1);
      lock = 1'b0;
      tick_exp("unlock.bubble", 4'h0, 4'h0, 16'd2);
      tick_exp("unlock.wb",     4'h8, 4'h0, 16'd2);

      // Reset pulse between edges during a stall.
      set_id(0, 0, 0, 0, 0, 11, 1, 1); tick_exp("lw11",      4'h0, 4'h0, 16'd2);
      set_id(11, 0, 1, 0, 0, 0, 0, 0);
      #1 check_eq("prerst.stall", {31'd0, stall}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst.alu",   {28'd0, alu}, 32'd0);
      check_eq("rst.cnt",   {16'd0, cnt}, 32'd0);
      check_eq("rst.stall", {31'd0, stall}, 32'd0);
      #1 rst_n = 1'b1;
      #1 check_eq("postrst.stall", {31'd0, stall}, 32'd0);
      tick_exp("postrst", 4'h0, 4'h0, 16'd0);

      // Saturation of the 4-bit copy; main counter keeps counting.
      for (int i = 1; i <= 18; i++) begin
         set_id(0, 0, 0, 0, 0, 8, 1, 1); tick_exp("sat.lw",  4'h0, 4'h0, 16'(i - 1));
         set_id(8, 0, 1, 0, 0, 0, 0, 0); tick_exp("sat.use", 4'h0, 4'h0, 16'(i));
         check_eq("sat.cnt4", {28'd0, s_cnt}, (i > 15) ? 32'd15 : 32'(i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
